// File: rtl/uart_tx_ram_ctrl.sv
// Transmit sequencer: streams cmd_len bytes from a registered byte RAM into an 8N1 transmitter.
// Define UART_TX_RAM_CTRL_CHKSUM_EN to append a mod-256 checksum byte after the data bytes.
module uart_tx_ram_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  output logic              busy,
  output logic              done,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_rd_data,
  output logic              tx_ready,
  output logic [7:0]        tx_data,
  input  logic              tx_bits_ok
);

`ifdef UART_TX_RAM_CTRL_CHKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_RD, ST_CAP, ST_REQ, ST_SER, ST_CSUM, ST_DONE
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_RD, ST_CAP, ST_REQ, ST_SER, ST_DONE
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [7:0]        tx_data_q, tx_data_d;
`ifdef UART_TX_RAM_CTRL_CHKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              last_q, last_d;  // checksum byte already queued
`endif

  // NOTE: every register updates with <= so all of them see pre-edge values,
  // regardless of the order the statements are written in.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      tx_data_q <= 8'h00;
`ifdef UART_TX_RAM_CTRL_CHKSUM_EN
      sum_q     <= 8'h00;
      last_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      tx_data_q <= tx_data_d;
`ifdef UART_TX_RAM_CTRL_CHKSUM_EN
      sum_q     <= sum_d;
      last_q    <= last_d;
`endif
    end
  end

  // NOTE: every output and next-state value gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    tx_data_d = tx_data_q;
`ifdef UART_TX_RAM_CTRL_CHKSUM_EN
    sum_d     = sum_q;
    last_d    = last_q;
`endif
    done      = 1'b0;
    ram_rd_en = 1'b0;
    tx_ready  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          addr_d   = cmd_addr;
          remain_d = cmd_len;
`ifdef UART_TX_RAM_CTRL_CHKSUM_EN
          sum_d    = 8'h00;
          last_d   = 1'b0;
`endif
          state_d  = (cmd_len == '0) ? ST_DONE : ST_RD;
        end
      end
      ST_RD: begin
        ram_rd_en = 1'b1;
        state_d   = ST_CAP;
      end
      ST_CAP: begin
        tx_data_d = ram_rd_data;
`ifdef UART_TX_RAM_CTRL_CHKSUM_EN
        sum_d     = sum_q + ram_rd_data;
`endif
        addr_d    = addr_q + 1'b1;
        remain_d  = remain_q - 1'b1;
        state_d   = ST_REQ;
      end
      ST_REQ: begin
        // tx_bits_ok dropping means the transmitter has latched tx_data.
        tx_ready = 1'b1;
        if (!tx_bits_ok) state_d = ST_SER;
      end
      ST_SER: begin
        // Stop bit has started; refetch now so the next START chains directly.
        if (tx_bits_ok) begin
          if (remain_q != '0) begin
            state_d = ST_RD;
          end else begin
`ifdef UART_TX_RAM_CTRL_CHKSUM_EN
            state_d = last_q ? ST_DONE : ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef UART_TX_RAM_CTRL_CHKSUM_EN
      ST_CSUM: begin
        tx_data_d = sum_q;
        last_d    = 1'b1;
        state_d   = ST_REQ;
      end
`endif
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign ram_addr = addr_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_ram_ctrl.sv
// Self-checking bench for uart_tx_ram_ctrl: behavioural RAM and 8N1 transmitter,
// expected byte stream computed directly from RAM contents, address and length.
module tb_uart_tx_ram_ctrl;
  localparam int BIT = 8;  // clocks per UART bit
`ifdef UART_TX_RAM_CTRL_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [1:0] M_IDLE = 2'd0, M_START = 2'd1, M_DATA = 2'd2, M_STOP = 2'd3;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_start = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [8:0] cmd_len = 9'd0;
  logic       busy, done, ram_rd_en, tx_ready, tx_bits_ok;
  logic [7:0] ram_addr, tx_data;
  logic [7:0] ram_rd_data = 8'h00;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [7:0] sent_q [$];
  logic [7:0] rd_q [$];
  int         done_cnt, gaps, stab_err, ready_cnt;
  bit         done_in_stop;
  logic       prev_rdy;
  logic [7:0] prev_d;

  logic [1:0] m_st;
  int         m_cnt, m_bit;
  logic [7:0] m_sh;
  logic       txd;

  uart_tx_ram_ctrl #(.ADDR_W(8)) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .cmd_start   (cmd_start),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .busy        (busy),
    .done        (done),
    .ram_rd_en   (ram_rd_en),
    .ram_addr    (ram_addr),
    .ram_rd_data (ram_rd_data),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_bits_ok  (tx_bits_ok)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_addr];
  end

  // Behavioural 8N1 transmitter; chains START right after STOP when a byte is waiting.
  assign tx_bits_ok = (m_st == M_IDLE) || (m_st == M_STOP);
  assign txd = (m_st == M_START) ? 1'b0 : (m_st == M_DATA) ? m_sh[0] : 1'b1;

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st  <= M_IDLE;
      m_cnt <= 0;
      m_bit <= 0;
      m_sh  <= 8'h00;
    end else begin
      case (m_st)
        M_IDLE: if (tx_ready) begin
          m_sh  <= tx_data;
          m_cnt <= 0;
          m_st  <= M_START;
          sent_q.push_back(tx_data);
        end
        M_START: if (m_cnt == BIT-1) begin
          m_cnt <= 0;
          m_bit <= 0;
          m_st  <= M_DATA;
        end else m_cnt <= m_cnt + 1;
        M_DATA: if (m_cnt == BIT-1) begin
          m_cnt <= 0;
          m_sh  <= {1'b0, m_sh[7:1]};
          if (m_bit == 7) m_st <= M_STOP;
          else m_bit <= m_bit + 1;
        end else m_cnt <= m_cnt + 1;
        default: if (m_cnt == BIT-1) begin
          m_cnt <= 0;
          if (tx_ready) begin
            m_sh <= tx_data;
            m_st <= M_START;
            sent_q.push_back(tx_data);
          end else begin
            m_st <= M_IDLE;
            if (busy) gaps <= gaps + 1;
          end
        end else m_cnt <= m_cnt + 1;
      endcase
    end
  end

  always @(posedge sys_clk) begin
    if (rst_n) begin
      if (ram_rd_en) rd_q.push_back(ram_addr);
      if (done) begin
        done_cnt     <= done_cnt + 1;
        done_in_stop <= (m_st == M_STOP);
      end
      if (tx_ready) ready_cnt <= ready_cnt + 1;
      if (tx_ready && prev_rdy && (tx_data !== prev_d)) stab_err <= stab_err + 1;
      prev_rdy <= tx_ready;
      prev_d   <= tx_data;
    end else begin
      prev_rdy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},      busy,      1'b0);
    check({tag, "_done"},      done,      1'b0);
    check({tag, "_ram_rd_en"}, ram_rd_en, 1'b0);
    check({tag, "_ram_addr"},  ram_addr,  8'h00);
    check({tag, "_tx_ready"},  tx_ready,  1'b0);
    check({tag, "_tx_data"},   tx_data,   8'h00);
    check({tag, "_txd"},       txd,       1'b1);
  endtask

  task automatic clear_mon();
    sent_q.delete();
    rd_q.delete();
    done_cnt     = 0;
    gaps         = 0;
    stab_err     = 0;
    ready_cnt    = 0;
    done_in_stop = 1'b0;
  endtask

  // Returns at the negedge of cycle N+1 (cmd_start sampled at edge N).
  task automatic issue(input logic [7:0] a, input logic [8:0] len);
    @(negedge sys_clk);
    clear_mon();
    cmd_addr  = a;
    cmd_len   = len;
    cmd_start = 1'b1;
    @(negedge sys_clk);
    cmd_start = 1'b0;
  endtask

  task automatic run_cmd(input logic [7:0] a, input logic [8:0] len, input bit inject);
    logic [7:0] exp_q [$];
    logic [7:0] exp_a [$];
    logic [7:0] s;
    int budget;
    int cyc;
    s = 8'h00;
    for (int i = 0; i < int'(len); i++) begin
      logic [7:0] ad;
      ad = a + 8'(i);
      exp_a.push_back(ad);
      exp_q.push_back(mem[ad]);
      s = s + mem[ad];
    end
    if (CHK && len != 9'd0) exp_q.push_back(s);

    issue(a, len);
    if (len == 9'd0) begin
      check("len0_done",     done,      1'b1);
      check("len0_busy",     busy,      1'b1);
      check("len0_rd_en",    ram_rd_en, 1'b0);
      check("len0_tx_ready", tx_ready,  1'b0);
      @(negedge sys_clk);
      check("len0_busy_end", busy,      1'b0);
      check("len0_done_end", done,      1'b0);
    end else begin
      check("start_busy",    busy,      1'b1);
      check("start_rd_en",   ram_rd_en, 1'b1);
      check("start_addr",    ram_addr,  a);
      @(negedge sys_clk);
      @(negedge sys_clk);
      check("first_ready",   tx_ready,  1'b1);
      check("first_data",    tx_data,   mem[a]);
    end

    if (inject) begin
      repeat (2*BIT) @(negedge sys_clk);
      cmd_addr  = a ^ 8'h5A;
      cmd_len   = 9'd7;
      cmd_start = 1'b1;
      @(negedge sys_clk);
      cmd_start = 1'b0;
    end

    budget = (int'(len) + 2) * 12 * BIT + 50;
    cyc = 0;
    while (done_cnt == 0 && cyc < budget) begin
      @(negedge sys_clk);
      cyc++;
    end
    check("done_seen", (done_cnt != 0), 1'b1);
    repeat (3*BIT) @(negedge sys_clk);

    check("done_count", done_cnt, 1);
    check("byte_count", sent_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
      check($sformatf("byte%0d", i), sent_q[i], exp_q[i]);
    check("read_count", rd_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < rd_q.size(); i++)
      check($sformatf("read_addr%0d", i), rd_q[i], exp_a[i]);
    check("idle_gaps", gaps, 0);
    check("ready_data_stable", stab_err, 0);
    if (len != 9'd0) check("done_in_stop", done_in_stop, 1'b1);
    else             check("len0_ready_cycles", ready_cnt, 0);
    check("end_busy", busy, 1'b0);
    check("end_txd",  txd,  1'b1);
  endtask

  task automatic mid_reset(input logic [7:0] a);
    int cyc;
    issue(a, 9'd3);
    cyc = 0;
    while (sent_q.size() < 2 && cyc < 40*BIT) begin
      @(negedge sys_clk);
      cyc++;
    end
    check("rst_reach_byte2", sent_q.size(), 2);
    repeat (3*BIT) @(negedge sys_clk);
    check("rst_busy_before", busy, 1'b1);
    @(posedge sys_clk);
    #1 rst_n = 1'b0;
    #1 check_reset("rst_mid");
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    clear_mon();

    repeat (3) @(negedge sys_clk);
    check_reset("por");
    rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    check_reset("idle");
    check("idle_no_reads", rd_q.size(), 0);

    mem[8'h10] = 8'h55;
    mem[8'h11] = 8'hA3;
    mem[8'h12] = 8'h0F;
    run_cmd(8'h10, 9'd3, 1'b0);
    run_cmd(8'hFE, 9'd4, 1'b0);
    run_cmd(8'h33, 9'd0, 1'b0);
    run_cmd(8'h20, 9'd5, 1'b1);

    mid_reset(8'($urandom));
    run_cmd(8'($urandom), 9'd3, 1'b0);

    for (int k = 0; k < 6; k++)
      run_cmd(8'($urandom), 9'($urandom_range(0, 6)), 1'b0);

    run_cmd(8'($urandom), 9'd256, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ram_ctrl.md
# uart_tx_ram_ctrl

Transmit sequencer between the byte RAM and the 8N1 UART transmitter in the UART/RAM design. On a command it reads `cmd_len` bytes from RAM starting at `cmd_addr` and feeds them one by one into the transmitter through its `tx_ready` / `tx_data_i` / `tx_bits_ok` handshake. It sends bytes back-to-back with no idle bit between them, and signals completion with a one-cycle `done` pulse.

## Interface
Parameters:
- `ADDR_W`, default 8: RAM address width. The length field is `ADDR_W+1` bits wide, so a full-RAM dump is possible.

Ports:
- `sys_clk` in 1: system clock (100 MHz).
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_start` in 1: command strobe; sampled only in IDLE.
- `cmd_addr` in ADDR_W: first RAM address; sampled with `cmd_start`.
- `cmd_len` in ADDR_W+1: number of bytes; 0 is legal.
- `busy` out 1: command in progress (state != IDLE).
- `done` out 1: one-cycle completion pulse.
- `ram_rd_en` out 1: RAM read strobe.
- `ram_addr` out ADDR_W: RAM read address.
- `ram_rd_data` in 8: RAM read data, valid the cycle after `ram_rd_en` (registered RAM).
- `tx_ready` out 1: to transmitter `tx_ready`; level request.
- `tx_data` out 8: to transmitter `tx_data_i`.
- `tx_bits_ok` in 1: from transmitter; 1 in IDLE/STOP, 0 while the start/data bits are on the line.

## Operation
- State machine: IDLE, RD, CAP, REQ, SER, CSUM, DONE.
- **IDLE:** on `cmd_start`, latch `addr = cmd_addr`, `remain = cmd_len`, clear `sum`.
  - If `cmd_len == 0`, go to DONE.
  - Otherwise go to RD.
- **RD:** `ram_rd_en = 1`, `ram_addr = addr`. Go to CAP.
- **CAP:** `tx_data <= ram_rd_data`, `sum <= sum + ram_rd_data` (mod 256), `addr <= addr + 1` (wraps at 2^ADDR_W), `remain <= remain - 1`. Go to REQ.
- **REQ:** `tx_ready = 1`, with `tx_data` held stable. Stay until `tx_bits_ok == 0`, which means the transmitter has accepted the byte. Then `tx_ready <= 0` and go to SER.
- **SER:** wait for `tx_bits_ok == 1` (the byte's stop bit has started). Then:
  - if `remain != 0`, go to RD;
  - else, with checksum enabled, go to CSUM;
  - else go to DONE.
- **CSUM:** `tx_data <= sum`. Go to REQ, flagged as the last byte; the following SER exits to DONE.
- **DONE:** `done = 1` for exactly one cycle, then IDLE.
- `cmd_start` outside IDLE is ignored. There is no abort; only `rst_n` cancels a command.
- Requesting during STOP lets the transmitter chain START directly after STOP: no idle bit between bytes.

## Timing
- Reset values: `busy=0`, `done=0`, `ram_rd_en=0`, `ram_addr=0`, `tx_ready=0`, `tx_data=8'h00`; state IDLE, `sum=0`.
- `cmd_start` high at edge N:
  - `busy=1` from N+1;
  - RD (`ram_rd_en=1`) in cycle N+1;
  - `tx_data` valid from N+3;
  - `tx_ready=1` from N+3.
- `cmd_len == 0`: `done` high in cycle N+1, `busy` high for that cycle only, no RAM read, no `tx_ready`.
- `tx_ready` stays high from REQ entry until the cycle after `tx_bits_ok` is seen low; at most one bit period plus 1 cycle.
- `tx_data` must not change while `tx_ready == 1`.
- Next-byte fetch: after the `tx_bits_ok` rising edge it takes 3 cycles (SER→RD→CAP→REQ). This is well inside one stop-bit period, so bytes go out back-to-back.
- `done` asserts 1 cycle after SER sees `tx_bits_ok` rise for the final byte, i.e. at the start of its stop bit. The stop bit is still on the line at that point.
- `rst_n` low mid-command: all outputs take reset values immediately (asynchronous). A partially sent byte is the transmitter's own reset concern.

## Configuration
- `UART_TX_RAM_CTRL_CHKSUM_EN` defined: after the last data byte, one extra byte equal to the 8-bit sum of all sent data bytes (mod 256) is sent. A `cmd_len == 0` command still sends nothing.
- Not defined: the CSUM state and `sum` register are compiled out; exactly `cmd_len` bytes are sent.

## Test plan
- Reset with no command → `busy=0`, `tx_ready=0`, `tx_data=0x00`, no `ram_rd_en`, txd idle high.
- RAM[0x10..0x12] = 0x55, 0xA3, 0x0F; start `addr=0x10`, `len=3` → line shows 0x55, 0xA3, 0x0F back-to-back with no idle bit; one `done` pulse. With CHKSUM_EN a fourth byte 0x07 follows.
- `addr=0xFE`, `len=4` → reads 0xFE, 0xFF, 0x00, 0x01 in order (wrap-around); 4 bytes sent (5 with CHKSUM_EN).
- `len=0` → `done` in cycle N+1, `busy` high for one cycle, no `ram_rd_en`, no `tx_ready`.
- `cmd_start` pulsed again mid-transfer with different addr/len → ignored; original transfer completes unchanged, exactly one `done`.
- `rst_n` low during byte 2 of a 3-byte transfer → all outputs at reset values the same cycle; a new command after release runs normally from its own `cmd_addr`.
